apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
APB3 completer sitting directly downstream of the team's APB master on the same PCLK/PRESETn bus. Provides a bank of NUM_REGS 32-bit read/write registers plus one read-only transfer-count status register. Inserts a configurable number of wait states via PREADY and flags illegal accesses via PSLVERR. Used as the standard bus target in master-level benches and as a scratch/config register block in the design.

Parameters:
NUM_REGS, 8, number of R/W registers (1..64)
WAIT_STATES, 1, PREADY-low cycles inserted in each access phase (0..15)
BASE_ADDR, 32'h0000_0000, byte base address of register 0; must be 4-byte aligned

Ports:
PCLK  input  1  APB clock, rising edge
PRESETn  input  1  reset, asynchronous, active-low
PSEL  input  1  slave select
PENABLE  input  1  access-phase indicator
PWRITE  input  1  1=write, 0=read
PADDR  input  32  byte address
PWDATA  input  32  write data
PRDATA  output  32  read data, valid when PREADY=1 and PWRITE=0
PREADY  output  1  transfer-complete strobe
PSLVERR  output  1  error response, valid only when PREADY=1

Behaviour:
- Reset is PRESETn, asynchronous, active-low; clock is PCLK. During reset: all registers 0, status counter 0, FSM=IDLE, wait counter 0.
- Address decode: off = PADDR - BASE_ADDR; idx = off[31:2].
  - Legal R/W: PADDR[1:0]==0 and idx < NUM_REGS.
  - Status reg STAT: idx == NUM_REGS, read-only; holds completed-transfer count, 32-bit, wraps 0xFFFF_FFFF -> 0.
  - Anything else (misaligned, PADDR below BASE_ADDR, idx > NUM_REGS, write to STAT) is illegal.
- FSM states IDLE, ACCESS.
  - IDLE: on PSEL=1 and PENABLE=0 (setup phase) -> ACCESS; load wcnt <= WAIT_STATES.
  - ACCESS: wcnt decrements each cycle while nonzero. PREADY = PSEL & PENABLE & (wcnt==0), combinational.
  - Transfer completes on the edge where PSEL & PENABLE & PREADY: legal write commits PWDATA to reg[idx]; STAT += 1 for every completed transfer, legal or illegal, read or write; FSM -> IDLE.
  - Back-to-back: a new setup phase may arrive the cycle after completion and is accepted from IDLE.
- Outputs outside a completing cycle: PREADY=0, PRDATA=0, PSLVERR=0. Reset values of PRDATA, PREADY and PSLVERR are 0.
- Read data in the completing cycle: reg[idx] or STAT for legal reads, 0 for illegal reads. A write completing in the same cycle as a read of STAT shows the pre-increment value.
- Latency: WAIT_STATES=0 gives setup + 1 access cycle; otherwise setup + 1 + WAIT_STATES cycles.
- PSEL deasserted while in ACCESS before completion (protocol abort): FSM -> IDLE, no register write, no STAT increment.
- PENABLE=1 seen in IDLE without a prior setup phase: ignored, PREADY stays 0.
- PRESETn asserted mid-transfer: immediate return to reset state; a pending write is discarded.
- Address/data/PWRITE are sampled only in the completing cycle; the master holds them stable per APB.

Optional Feature:
APB_SLV_ERR_EN
- Defined: illegal accesses drive PSLVERR=1 in the completing cycle. Illegal writes do not modify any register.
- Undefined: PSLVERR tied to 0. Illegal writes are silently dropped, illegal reads return 0. Timing and STAT counting are unchanged.

Test Plan:
- Reset: PRESETn low 3 cycles -> PREADY=0, PRDATA=0, PSLVERR=0; read of every reg and STAT returns 0x0000_0000.
- Write/read-back, WAIT_STATES=1: write 0xDEAD_BEEF to BASE+0x04, then read BASE+0x04 -> PREADY low for exactly 1 access cycle; read returns 0xDEAD_BEEF; STAT reads 2 on the next read (read of STAT itself returns 2, then the counter becomes 3).
- Zero-wait build (WAIT_STATES=0): 8 back-to-back writes of value i*0x11 to reg i, then readback -> each transfer is 2 cycles, all values match, STAT=16 before the STAT read completes.
- Error path with APB_SLV_ERR_EN: write 0x1234_5678 to BASE+0x02 (misaligned), to BASE+NUM_REGS*4 (STAT), and to BASE+0x100 -> PSLVERR=1 with PREADY each time; regs unchanged; STAT still increments. Without the macro: PSLVERR=0, same register contents.
- Abort: setup for a write of 0xAAAA_5555 to reg 3 with WAIT_STATES=3, drop PSEL after 1 access cycle -> reg 3 keeps its old value, STAT unchanged, next transfer completes normally.
- Reset mid-op: assert PRESETn low during the access phase of a write to reg 2 -> all outputs 0 immediately; reg 2 reads 0 after release.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB3 completer: NUM_REGS read/write registers plus a read-only completed-transfer counter.
// Define APB_SLV_ERR_EN to report illegal accesses on PSLVERR; otherwise PSLVERR is tied low.
module apb_regfile_slave #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [29:0] STAT_IDX  = 30'(NUM_REGS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;

  if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_bad_num_regs
    $error("apb_regfile_slave: NUM_REGS must be in 1..64");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("apb_regfile_slave: WAIT_STATES must be in 0..15");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("apb_regfile_slave: BASE_ADDR must be 4-byte aligned");
  end

  logic             state_q;
  logic [3:0]       wcnt_q;
  logic [31:0]      regs_q [NUM_REGS];
  logic [31:0]      stat_q;

  logic [29:0]      idx;
  logic [IDX_W-1:0] reg_idx;
  logic             below_base;
  logic             aligned;
  logic             hit_reg;
  logic             hit_stat;
  logic             xfer_done;
  logic             wr_commit;
  logic [31:0]      rdata_mux;

  // Word index relative to BASE_ADDR; an address below the base wraps and is rejected separately.
  always_comb begin
    idx        = 30'((PADDR - BASE_ADDR) >> 2);
    reg_idx    = idx[IDX_W-1:0];
    below_base = (PADDR < BASE_ADDR);
    aligned    = (PADDR[1:0] == 2'b00);
    hit_reg    = aligned && !below_base && (idx < STAT_IDX);
    hit_stat   = aligned && !below_base && (idx == STAT_IDX);
  end

  // A transfer completes only from ACCESS, so a stray PENABLE seen in IDLE never raises PREADY.
  assign PREADY    = (state_q == ST_ACCESS) && PSEL && PENABLE && (wcnt_q == 4'd0);
  assign xfer_done = PREADY;
  assign wr_commit = xfer_done && PWRITE && hit_reg;

  // NOTE: every path assigns rdata_mux after its default, so no latch is inferred.
  always_comb begin
    rdata_mux = 32'h0000_0000;
    if (xfer_done && !PWRITE) begin
      if (hit_reg) begin
        rdata_mux = regs_q[reg_idx];
      end else if (hit_stat) begin
        rdata_mux = stat_q;
      end
    end
  end

  assign PRDATA = rdata_mux;

`ifdef APB_SLV_ERR_EN
  logic illegal;
  assign illegal = !(hit_reg || (hit_stat && !PWRITE));
  assign PSLVERR = xfer_done && illegal;
`else
  assign PSLVERR = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            state_q <= ST_ACCESS;
            wcnt_q  <= WAIT_INIT;
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
          end else if (xfer_done) begin
            state_q <= ST_IDLE;
          end else if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wcnt_q  <= 4'd0;
        end
      endcase
    end
  end

  // NOTE: the register bank sits on the async reset because software expects every register to read 0.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else if (wr_commit) begin
      regs_q[reg_idx] <= PWDATA;
    end
  end

  // Counts every completed transfer, legal or not; aborted transfers never complete.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      stat_q <= 32'h0000_0000;
    end else if (xfer_done) begin
      stat_q <= stat_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench for apb_regfile_slave: three instances (1, 0 and 3 wait states)
// checked every cycle against a transfer-level register/counter model.
module tb_apb_regfile_slave;

`ifdef APB_SLV_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        PCLK;
  logic        rst_n;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  logic        exp_ready [3];
  logic [31:0] exp_rdata [3];
  logic        exp_err   [3];

  logic [31:0] mreg  [3][64];
  logic [31:0] mstat [3];

  int n_checks = 0;
  int n_errors = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_regfile_slave #(.NUM_REGS(8), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .PCLK(PCLK), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_regfile_slave #(.NUM_REGS(8), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut1 (
    .PCLK(PCLK), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_regfile_slave #(.NUM_REGS(5), .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000)) u_dut2 (
    .PCLK(PCLK), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int nregs_of(input int d);
    return (d == 2) ? 5 : 8;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  // -1: illegal address; 0..n-1: register; n: status counter.
  function automatic int decode(input int d, input logic [31:0] addr);
    logic [31:0] base;
    logic [31:0] off;
    base = base_of(d);
    if (addr < base || addr[1:0] != 2'b00) return -1;
    off = (addr - base) >> 2;
    if (off > 32'(nregs_of(d))) return -1;
    return int'(off);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mstat[d]     = 32'h0;
      exp_ready[d] = 1'b0;
      exp_rdata[d] = 32'h0;
      exp_err[d]   = 1'b0;
      for (int i = 0; i < 64; i++) mreg[d][i] = 32'h0;
    end
  endtask

  task automatic bus_idle(input int d);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b0;
    paddr[d]   = 32'h0;
    pwdata[d]  = 32'h0;
  endtask

  // Per-cycle comparison of all three instances against the model's expectations.
  always @(negedge PCLK) begin
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d PREADY", d), {31'b0, pready[d]}, {31'b0, exp_ready[d]});
      check($sformatf("dut%0d PRDATA", d), prdata[d], exp_rdata[d]);
      check($sformatf("dut%0d PSLVERR", d), {31'b0, pslverr[d]}, {31'b0, exp_err[d]});
    end
  end

  // Called #1 after a rising edge; returns #1 after the completing edge so calls chain back-to-back.
  // cycles is measured from the DUT (setup cycle + access cycles up to the first PREADY), 0 if never seen.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int cycles);
    int ws;
    int k;
    int nr;
    ws = ws_of(d);
    nr = nregs_of(d);
    k  = decode(d, addr);
    cycles = 0;
    rdata  = 32'h0;
    err    = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
    @(posedge PCLK); #1;
    penable[d] = 1'b1;
    for (int n = 0; n <= ws; n++) begin
      if (n == ws) begin
        exp_ready[d] = 1'b1;
        exp_rdata[d] = 32'h0;
        if (!wr && k >= 0) exp_rdata[d] = (k < nr) ? mreg[d][k] : mstat[d];
        exp_err[d]   = ERR_EN && (k < 0 || (wr && k == nr));
      end
      @(negedge PCLK);
      if (cycles == 0 && pready[d]) cycles = n + 2;
      rdata = prdata[d];
      err   = pslverr[d];
      @(posedge PCLK); #1;
    end
    if (wr && k >= 0 && k < nr) mreg[d][k] = wdata;
    mstat[d] = mstat[d] + 32'd1;
    exp_ready[d] = 1'b0; exp_rdata[d] = 32'h0; exp_err[d] = 1'b0;
    bus_idle(d);
  endtask

  task automatic apb_abort(input int d, input logic [31:0] addr, input logic [31:0] wdata, input int access_cycles);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1; paddr[d] = addr; pwdata[d] = wdata;
    @(posedge PCLK); #1;
    penable[d] = 1'b1;
    repeat (access_cycles) begin
      @(posedge PCLK); #1;
    end
    bus_idle(d);
    @(posedge PCLK); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) bus_idle(d);
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) bus_idle(d);
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    check("reset PREADY", {31'b0, pready[0]}, 32'h0);
    check("reset PRDATA", prdata[0], 32'h0);
    check("reset PSLVERR", {31'b0, pslverr[0]}, 32'h0);
    rst_n = 1'b1;

    // Reset contents: status first so the counter itself is still 0.
    for (int d = 0; d < 3; d++) begin
      apb_xfer(d, 1'b0, base_of(d) + 32'(nregs_of(d) * 4), 32'h0, rd, er, cyc);
      check($sformatf("dut%0d reset STAT", d), rd, 32'h0);
      for (int i = 0; i < nregs_of(d); i++) begin
        apb_xfer(d, 1'b0, base_of(d) + 32'(i * 4), 32'h0, rd, er, cyc);
        check($sformatf("dut%0d reset reg%0d", d, i), rd, 32'h0);
      end
    end

    do_reset();

    // One wait state: write/read-back and counter.
    apb_xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF, rd, er, cyc);
    check("ws1 write cycles", 32'(cyc), 32'd3);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, er, cyc);
    check("ws1 read cycles", 32'(cyc), 32'd3);
    check("ws1 readback", rd, 32'hDEAD_BEEF);
    apb_xfer(0, 1'b0, 32'h20, 32'h0, rd, er, cyc);
    check("ws1 STAT first", rd, 32'd2);
    apb_xfer(0, 1'b0, 32'h20, 32'h0, rd, er, cyc);
    check("ws1 STAT second", rd, 32'd3);

    // Illegal accesses.
    apb_xfer(0, 1'b1, 32'h02, 32'h1234_5678, rd, er, cyc);
    check("err misaligned write", {31'b0, er}, {31'b0, ERR_EN});
    apb_xfer(0, 1'b1, 32'h20, 32'h1234_5678, rd, er, cyc);
    check("err STAT write", {31'b0, er}, {31'b0, ERR_EN});
    apb_xfer(0, 1'b1, 32'h100, 32'h1234_5678, rd, er, cyc);
    check("err out-of-range write", {31'b0, er}, {31'b0, ERR_EN});
    check("err write cycles", 32'(cyc), 32'd3);
    apb_xfer(0, 1'b0, 32'h00, 32'h0, rd, er, cyc);
    check("err reg0 untouched", rd, 32'h0);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, er, cyc);
    check("err reg1 untouched", rd, 32'hDEAD_BEEF);
    apb_xfer(0, 1'b0, 32'h100, 32'h0, rd, er, cyc);
    check("err illegal read data", rd, 32'h0);
    check("err illegal read flag", {31'b0, er}, {31'b0, ERR_EN});
    apb_xfer(0, 1'b0, 32'h20, 32'h0, rd, er, cyc);
    check("err STAT count", rd, 32'd10);

    // Zero wait states, back-to-back.
    for (int i = 0; i < 8; i++) begin
      apb_xfer(1, 1'b1, 32'(i * 4), 32'(i * 32'h11), rd, er, cyc);
      check($sformatf("ws0 write%0d cycles", i), 32'(cyc), 32'd2);
    end
    for (int i = 0; i < 8; i++) begin
      apb_xfer(1, 1'b0, 32'(i * 4), 32'h0, rd, er, cyc);
      check($sformatf("ws0 read%0d cycles", i), 32'(cyc), 32'd2);
      check($sformatf("ws0 read%0d data", i), rd, 32'(i * 32'h11));
    end
    apb_xfer(1, 1'b0, 32'h20, 32'h0, rd, er, cyc);
    check("ws0 STAT", rd, 32'd16);

    // Three wait states, non-zero base, abort.
    apb_xfer(2, 1'b1, 32'h100C, 32'h0BAD_F00D, rd, er, cyc);
    check("ws3 write cycles", 32'(cyc), 32'd5);
    apb_abort(2, 32'h100C, 32'hAAAA_5555, 1);
    apb_xfer(2, 1'b0, 32'h100C, 32'h0, rd, er, cyc);
    check("abort reg3 kept", rd, 32'h0BAD_F00D);
    check("abort next cycles", 32'(cyc), 32'd5);
    apb_xfer(2, 1'b0, 32'h0FFC, 32'h0, rd, er, cyc);
    check("below-base read data", rd, 32'h0);
    check("below-base read flag", {31'b0, er}, {31'b0, ERR_EN});
    apb_xfer(2, 1'b1, 32'h1018, 32'h7777_7777, rd, er, cyc);
    check("beyond-STAT write flag", {31'b0, er}, {31'b0, ERR_EN});
    apb_xfer(2, 1'b0, 32'h1014, 32'h0, rd, er, cyc);
    check("abort STAT", rd, 32'd4);

    // Reset asserted in the completing cycle of a write to reg 2.
    apb_xfer(2, 1'b1, 32'h1008, 32'h5A5A_5A5A, rd, er, cyc);
    apb_xfer(2, 1'b0, 32'h1008, 32'h0, rd, er, cyc);
    check("pre-reset reg2", rd, 32'h5A5A_5A5A);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h1008; pwdata[2] = 32'h1111_1111;
    @(posedge PCLK); #1;
    penable[2] = 1'b1;
    repeat (3) begin
      @(posedge PCLK); #1;
    end
    check("mid-op PREADY before reset", {31'b0, pready[2]}, 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid-op PREADY in reset", {31'b0, pready[2]}, 32'h0);
    check("mid-op PRDATA in reset", prdata[2], 32'h0);
    check("mid-op PSLVERR in reset", {31'b0, pslverr[2]}, 32'h0);
    bus_idle(2);
    repeat (2) @(posedge PCLK);
    #1;
    rst_n = 1'b1;
    apb_xfer(2, 1'b0, 32'h1008, 32'h0, rd, er, cyc);
    check("post-reset reg2", rd, 32'h0);
    apb_xfer(2, 1'b0, 32'h1014, 32'h0, rd, er, cyc);
    check("post-reset STAT", rd, 32'd1);

    repeat (2) @(posedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
